// File: rtl/cyber_war_pkg.sv
// Shared types and constants for the cyber war score-keeping logic.
package cyber_war_pkg;

    localparam int SCORE_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTART = 2'd1,
        RELEASE = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/score_counter.sv
// Per-player round-win counter: synchronous clear, increment saturating at SCORE_MAX.
module score_counter
    import cyber_war_pkg::*;
#(
    parameter int SCORE_MAX = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr,
    output logic [SCORE_W-1:0] count
);

    localparam logic [SCORE_W-1:0] MAX_CNT = SCORE_W'(SCORE_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_CNT)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Round/game controller: counts round wins per player, pulses a re-centre request
// after each round and flags the winner once a player reaches SCORE_MAX.
module score_keeper
    import cyber_war_pkg::*;
#(
    parameter int SCORE_MAX = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               left_win,
    input  logic               right_win,
    input  logic               clear,
    output logic [SCORE_W-1:0] left_score,
    output logic [SCORE_W-1:0] right_score,
    output logic               round_restart,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam logic [SCORE_W-1:0] MAX_CNT = SCORE_W'(SCORE_MAX);

    state_t     state;
    state_t     state_next;
    logic       inc_left;
    logic       inc_right;
    logic [1:0] winner_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            round_restart <= 1'b0;
            game_over     <= 1'b0;
            winner        <= WIN_NONE;
        end else begin
            state         <= state_next;
            round_restart <= (state_next == RESTART);
            game_over     <= (state_next == OVER);
            winner        <= winner_next;
        end
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_comb begin
        state_next  = state;
        inc_left    = 1'b0;
        inc_right   = 1'b0;
        winner_next = winner;
        if (clear) begin
            state_next  = IDLE;
            winner_next = WIN_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (left_win || right_win) begin
                        inc_left   = left_win && !right_win;
                        inc_right  = right_win && !left_win;
                        state_next = RESTART;
                    end
                end
                RESTART: begin
                    if (left_score == MAX_CNT) begin
                        state_next  = OVER;
                        winner_next = WIN_LEFT;
                    end else if (right_score == MAX_CNT) begin
                        state_next  = OVER;
                        winner_next = WIN_RIGHT;
                    end else begin
                        state_next = RELEASE;
                    end
                end
                RELEASE: begin
                    // A held win must drop before the next round can be counted.
                    if (!left_win && !right_win) begin
                        state_next = IDLE;
                    end
                end
                OVER: begin
                    state_next = OVER;
                end
                default: begin
                    state_next  = IDLE;
                    winner_next = WIN_NONE;
                end
            endcase
        end
    end

    score_counter #(
        .SCORE_MAX(SCORE_MAX)
    ) u_left (
        .clk  (clk),
        .reset(reset),
        .inc  (inc_left),
        .clr  (clear),
        .count(left_score)
    );

    score_counter #(
        .SCORE_MAX(SCORE_MAX)
    ) u_right (
        .clk  (clk),
        .reset(reset),
        .inc  (inc_right),
        .clr  (clear),
        .count(right_score)
    );

endmodule

// File: tb/tb_score_keeper.sv
// Randomized bench for score_keeper (SCORE_MAX=7 and SCORE_MAX=3) against a rule-level model.
module tb_score_keeper;

    logic       clk;
    logic       reset;
    logic       left_win;
    logic       right_win;
    logic       clear;
    logic [2:0] ls7, rs7, ls3, rs3;
    logic       rr7, go7, rr3, go3;
    logic [1:0] wn7, wn3;

    int tests = 0;
    int fails = 0;

    // Model state, index 0 = SCORE_MAX 7, index 1 = SCORE_MAX 3
    int       m_max [2] = '{7, 3};
    int       m_ls  [2];
    int       m_rs  [2];
    bit       m_rr  [2];
    bit       m_go  [2];
    bit       m_rel [2];
    int       m_wn  [2];

    score_keeper #(.SCORE_MAX(7)) dut7 (
        .clk(clk), .reset(reset), .left_win(left_win), .right_win(right_win), .clear(clear),
        .left_score(ls7), .right_score(rs7), .round_restart(rr7), .game_over(go7), .winner(wn7)
    );

    score_keeper #(.SCORE_MAX(3)) dut3 (
        .clk(clk), .reset(reset), .left_win(left_win), .right_win(right_win), .clear(clear),
        .left_score(ls3), .right_score(rs3), .round_restart(rr3), .game_over(go3), .winner(wn3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ls[k] = 0; m_rs[k] = 0; m_rr[k] = 0; m_go[k] = 0; m_rel[k] = 0; m_wn[k] = 0;
        end
    endtask

    // One rising edge of the game rules, applied to both model instances
    task automatic model_edge(input bit l, input bit r, input bit c);
        for (int k = 0; k < 2; k++) begin
            if (c) begin
                m_ls[k] = 0; m_rs[k] = 0; m_rr[k] = 0; m_go[k] = 0; m_rel[k] = 0; m_wn[k] = 0;
            end else if (m_rr[k]) begin
                m_rr[k] = 0;
                if (m_ls[k] == m_max[k]) begin
                    m_go[k] = 1; m_wn[k] = 1;
                end else if (m_rs[k] == m_max[k]) begin
                    m_go[k] = 1; m_wn[k] = 2;
                end else begin
                    m_rel[k] = 1;
                end
            end else if (m_go[k]) begin
                // game decided: everything frozen until clear/reset
            end else if (m_rel[k]) begin
                if (!l && !r) m_rel[k] = 0;
            end else if (l || r) begin
                if (l && !r && m_ls[k] < m_max[k]) m_ls[k]++;
                if (r && !l && m_rs[k] < m_max[k]) m_rs[k]++;
                m_rr[k] = 1;
            end
        end
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, " ls7"}, {5'd0, ls7}, 8'(m_ls[0]));
        check({ctx, " rs7"}, {5'd0, rs7}, 8'(m_rs[0]));
        check({ctx, " rr7"}, {7'd0, rr7}, 8'(m_rr[0]));
        check({ctx, " go7"}, {7'd0, go7}, 8'(m_go[0]));
        check({ctx, " wn7"}, {6'd0, wn7}, 8'(m_wn[0]));
        check({ctx, " ls3"}, {5'd0, ls3}, 8'(m_ls[1]));
        check({ctx, " rs3"}, {5'd0, rs3}, 8'(m_rs[1]));
        check({ctx, " rr3"}, {7'd0, rr3}, 8'(m_rr[1]));
        check({ctx, " go3"}, {7'd0, go3}, 8'(m_go[1]));
        check({ctx, " wn3"}, {6'd0, wn3}, 8'(m_wn[1]));
    endtask

    // Called with clk low just after a falling edge; inputs change only here.
    task automatic cycle(input bit l, input bit r, input bit c, input string ctx);
        left_win = l; right_win = r; clear = c;
        @(posedge clk);
        model_edge(l, r, c);
        @(negedge clk);
        compare_all(ctx);
    endtask

    // Reset asserted between edges; outputs must clear before the next rising edge.
    task automatic do_reset(input string ctx);
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all({ctx, " async"});
        @(posedge clk);
        @(negedge clk);
        compare_all({ctx, " held"});
        reset = 1'b1;
    endtask

    task automatic pulse(input bit l, input bit r, input string ctx);
        cycle(l, r, 1'b0, ctx);
        cycle(1'b0, 1'b0, 1'b0, ctx);
        cycle(1'b0, 1'b0, 1'b0, ctx);
    endtask

    initial begin
        int hold;
        bit l, r, c;
        reset = 1'b0; left_win = 1'b0; right_win = 1'b0; clear = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset("init");

        // Held left win counted once, single restart pulse
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, "hold_left");
        check("hold_left score", {5'd0, ls7}, 8'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, "hold_left_rel");

        // Simultaneous wins: tie round
        pulse(1'b1, 1'b1, "tie");
        check("tie score", {5'd0, ls7}, 8'd1);

        // Right reaches 7, eighth pulse ignored
        do_reset("pre_right");
        for (int i = 0; i < 8; i++) pulse(1'b0, 1'b1, "right_run");
        check("right7 score", {5'd0, rs7}, 8'd7);
        check("right7 over", {7'd0, go7}, 8'd1);
        check("right7 winner", {6'd0, wn7}, 8'd2);

        // Clear wins over a simultaneous left win in OVER
        cycle(1'b1, 1'b0, 1'b1, "clear_over");
        check("clear ls", {5'd0, ls7}, 8'd0);
        check("clear go", {7'd0, go7}, 8'd0);
        cycle(1'b0, 1'b0, 1'b0, "after_clear");

        // SCORE_MAX=3 left victory
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, "left3");
        check("left3 score", {5'd0, ls3}, 8'd3);
        check("left3 over", {7'd0, go3}, 8'd1);
        check("left3 winner", {6'd0, wn3}, 8'd1);

        // Reset during RESTART
        cycle(1'b0, 1'b0, 1'b1, "pre_rst");
        cycle(1'b1, 1'b0, 1'b0, "into_restart");
        check("in restart", {7'd0, rr7}, 8'd1);
        do_reset("restart_rst");

        // Win already high when reset releases counts on the first edge
        cycle(1'b0, 1'b1, 1'b0, "post_rst_win");
        check("post_rst rs", {5'd0, rs7}, 8'd1);

        // Randomized levels, occasional clear and reset
        for (int n = 0; n < 400; n++) begin
            l = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 39) == 0);
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) cycle(l, r, c && (h == 0), "rand");
            if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL declare parameter SCORE_MAX, default 7, the round-win count that ends the game (1..7).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low reset: low forces reset state immediately, independent of clk.
REQ-004 SHALL have port left_win, input, 1, level from the playfield, high while the left player holds a round win (may stay high many cycles).
REQ-005 SHALL have port right_win, input, 1, same as left_win for the right player.
REQ-006 SHALL have port clear, input, 1, synchronous new-game request.
REQ-007 SHALL have port left_score, output, 3, left round-win count, unsigned, feeds the left 7-segment decoder.
REQ-008 SHALL have port right_score, output, 3, right round-win count, unsigned, feeds the right 7-segment decoder.
REQ-009 SHALL have port round_restart, output, 1, one-cycle pulse telling the playfield to re-centre.
REQ-010 SHALL have port game_over, output, 1, high while the game is decided.
REQ-011 SHALL have port winner, output, 2, 2'b00 none, 2'b01 left, 2'b10 right; 2'b11 never driven.

Function
REQ-012 SHALL implement FSM states IDLE, RESTART, RELEASE, OVER; all outputs registered (Moore).
REQ-013 IDLE: at an edge where exactly one of left_win/right_win is high, that player's score SHALL increment by 1, visible after that edge; next state RESTART.
REQ-014 IDLE: at an edge where both win inputs are high, neither score SHALL change (tie round); next state RESTART.
REQ-015 IDLE with both win inputs low SHALL hold all state.
REQ-016 RESTART SHALL last exactly one cycle with round_restart=1; round_restart SHALL be 0 in every other state.
REQ-017 After RESTART, next state SHALL be OVER if either score equals SCORE_MAX, else RELEASE.
REQ-018 RELEASE SHALL ignore win inputs and return to IDLE at the first edge where both are low; a held win is counted once only.
REQ-019 OVER SHALL assert game_over=1 and set winner to the player whose score equals SCORE_MAX; scores frozen, win inputs ignored.
REQ-020 Scores SHALL saturate at SCORE_MAX and never wrap to 0.
REQ-021 clear=1 at an edge, in any state, SHALL zero both scores, game_over and winner, and go to IDLE; clear beats any simultaneous win.
REQ-022 Latency: win edge to score update 1 edge; win edge to round_restart high 1 cycle.

Reset
REQ-023 reset low SHALL asynchronously force state IDLE, left_score=0, right_score=0, round_restart=0, game_over=0, winner=2'b00.
REQ-024 Reset asserted mid-round (any state) SHALL drop round_restart at once and discard partial progress.
REQ-025 After reset is released, a win input already high SHALL be counted at the first clk edge (IDLE behaviour).

Structure
REQ-026 Shared package cyber_war_pkg SHALL hold SCORE_W=3, the state enum type, and the winner encoding constants.
REQ-027 Each player's count SHALL be a sub-module score_counter (inc, clr, saturate at SCORE_MAX, async active-low reset), instantiated twice.
REQ-028 Outputs left_score/right_score SHALL connect directly to the existing 3-bit to 7-segment decoder inputs with no extra logic.

Verification
REQ-029 Reset, then left_win high 5 cycles, low -> left_score=1 after first edge, round_restart high exactly 1 cycle, no further increment.
REQ-030 left_win and right_win rise on the same edge -> both scores unchanged, one round_restart pulse.
REQ-031 Seven separate right_win pulses (SCORE_MAX=7) -> right_score=7, game_over=1, winner=2'b10; an eighth pulse leaves all unchanged.
REQ-032 In OVER, clear=1 together with left_win=1 -> scores 0, game_over=0, winner=2'b00, state IDLE, no increment.
REQ-033 reset driven low between clock edges during RESTART -> round_restart and scores 0 immediately, before the next edge.
REQ-034 Parameter SCORE_MAX=3: three left wins -> game_over=1 with left_score=3.
